// File: rtl/sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package sweep_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   function automatic int unsigned tw_of(input int unsigned n);
      return 32'(1) << n;
   endfunction

   // Row 0 (all inputs low) lands in the MSB of the table code.
   function automatic int unsigned row_bit(input int unsigned tw, input int unsigned r);
      return tw - 32'(1) - r;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Controller/CUT-facing bundle of the truth-table sweeper.
interface truth_table_sweeper_if
   import sweep_pkg::*;
#(
   parameter int unsigned N_IN = 3
);
   localparam int unsigned TW = tw_of(N_IN);

   logic            start;
   logic [TW-1:0]   expected;
   logic            resp;
   logic [N_IN-1:0] stim;
   logic            busy;
   logic            done;
   logic [TW-1:0]   table_out;
   logic            match;
   logic [TW-1:0]   unstable_mask;

   modport master (
      output start, expected, resp,
      input  stim, busy, done, table_out, match, unstable_mask
   );

   modport slave (
      input  start, expected, resp,
      output stim, busy, done, table_out, match, unstable_mask
   );
endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; counts SETTLE_CYCLES-1 down to zero.
module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic zero_c
);
   localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= CW'(SETTLE_CYCLES - 1);
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - CW'(1);
      end
   end

   assign zero_c = (count_q == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input row into a CUT, captures its response as a hex truth-table
// code and compares it with an expected code. Option: SWEEP_STABLE_CHECK_EN.
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int unsigned N_IN          = 3,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   truth_table_sweeper_if.slave bus
);
   localparam int unsigned TW = tw_of(N_IN);
   localparam logic [N_IN-1:0] LAST_ROW = N_IN'(TW - 1);

   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 1");
   end

   state_t          state_q, state_nxt;
   logic [N_IN-1:0] stim_q, stim_nxt;
   logic [N_IN-1:0] row_q, row_nxt;
   logic [TW-1:0]   exp_q, exp_nxt;
   logic [TW-1:0]   table_q, table_nxt;
   logic [TW-1:0]   mask_q, mask_nxt;
   logic            busy_q, busy_nxt;
   logic            done_q, done_nxt;
   logic            match_q, match_nxt;
   logic            tmr_load_c, tmr_en_c, tmr_zero_c;
   logic [N_IN-1:0] bit_idx_c;

   settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load_c),
      .en     (tmr_en_c),
      .zero_c (tmr_zero_c)
   );

`ifdef SWEEP_STABLE_CHECK_EN
   // resp as seen on the previous edge, i.e. during the last SETTLE cycle
   logic prev_resp_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_resp_q <= 1'b0;
      else        prev_resp_q <= bus.resp;
   end
`endif

   assign bit_idx_c = N_IN'(row_bit(TW, 32'(row_q)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stim_q  <= '0;
         row_q   <= '0;
         exp_q   <= '0;
         table_q <= '0;
         mask_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         stim_q  <= stim_nxt;
         row_q   <= row_nxt;
         exp_q   <= exp_nxt;
         table_q <= table_nxt;
         mask_q  <= mask_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
         match_q <= match_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      stim_nxt   = stim_q;
      row_nxt    = row_q;
      exp_nxt    = exp_q;
      table_nxt  = table_q;
      mask_nxt   = mask_q;
      busy_nxt   = busy_q;
      done_nxt   = 1'b0;
      match_nxt  = match_q;
      tmr_load_c = 1'b0;
      tmr_en_c   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               exp_nxt    = bus.expected;
               table_nxt  = '0;
               mask_nxt   = '0;
               match_nxt  = 1'b0;
               row_nxt    = '0;
               stim_nxt   = '0;
               busy_nxt   = 1'b1;
               tmr_load_c = 1'b1;
               state_nxt  = SETTLE;
            end
         end
         SETTLE: begin
            if (tmr_zero_c) state_nxt = SAMPLE;
            else            tmr_en_c  = 1'b1;
         end
         SAMPLE: begin
            table_nxt[bit_idx_c] = bus.resp;
`ifdef SWEEP_STABLE_CHECK_EN
            if (bus.resp != prev_resp_q) mask_nxt[bit_idx_c] = 1'b1;
`endif
            if (row_q == LAST_ROW) begin
               // the final row's bit is folded into the comparison here
               done_nxt  = 1'b1;
               match_nxt = (table_nxt == exp_q) && (mask_nxt == '0);
               stim_nxt  = '0;
               state_nxt = DONE;
            end else begin
               row_nxt    = row_q + N_IN'(1);
               stim_nxt   = row_q + N_IN'(1);
               tmr_load_c = 1'b1;
               state_nxt  = SETTLE;
            end
         end
         DONE: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.stim          = stim_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.table_out     = table_q;
   assign bus.match         = match_q;
   assign bus.unstable_mask = mask_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper; expected mask depends on SWEEP_STABLE_CHECK_EN.
module tb_truth_table_sweeper;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] func = 8'h97;
   logic glitch = 1'b0;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(3)) bus ();
   truth_table_sweeper_if #(.N_IN(3)) bus1 ();

   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   // CUT model: row r answers with bit [7-r] of func, optionally inverted
   always_comb bus.resp = func[3'd7 - bus.stim] ^ glitch;
   assign bus1.resp = 1'b1;
   assign bus1.expected = 8'hFF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // start accepted at edge 0; records the first done edge, done count and stim walk errors
   task automatic sweep(input logic [7:0] e, input int poke_at, input int glitch_at,
                        output int done_edge, output int n_done, output int stim_err);
      @(negedge clk);
      bus.expected = e;
      bus.start = 1'b1;
      @(posedge clk); #1;
      done_edge = -1;
      n_done = 0;
      stim_err = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         bus.start = (k == poke_at);
         if (k == poke_at) bus.expected = ~e;
         glitch = (k == glitch_at);
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            n_done++;
            if (done_edge < 0) done_edge = k;
         end
         if (k < 40 && bus.stim !== 3'(k / 5)) stim_err++;
         if (k >= 40 && bus.stim !== 3'd0) stim_err++;
      end
      glitch = 1'b0;
   endtask

   initial begin
      int de, nd, se;
      bus.start = 1'b0;
      bus.expected = 8'h00;
      bus1.start = 1'b0;

      // reset state
      #12;
      chk("rst_stim", 32'(bus.stim), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_table", 32'(bus.table_out), 32'h0);
      chk("rst_match", 32'(bus.match), 32'h0);
      chk("rst_mask", 32'(bus.unstable_mask), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // matching sweep
      sweep(8'h97, -1, -1, de, nd, se);
      chk("t1_done_edge", 32'(de), 32'd40);
      chk("t1_done_count", 32'(nd), 32'd1);
      chk("t1_stim_walk", 32'(se), 32'd0);
      chk("t1_table", 32'(bus.table_out), 32'h97);
      chk("t1_match", 32'(bus.match), 32'h1);
      chk("t1_busy_after", 32'(bus.busy), 32'h0);
      chk("t1_mask", 32'(bus.unstable_mask), 32'h0);

      // wrong expected code
      sweep(8'hE9, -1, -1, de, nd, se);
      chk("t2_done_edge", 32'(de), 32'd40);
      chk("t2_table", 32'(bus.table_out), 32'h97);
      chk("t2_match", 32'(bus.match), 32'h0);

      // start re-pulsed and expected changed at edge 10
      sweep(8'h97, 10, -1, de, nd, se);
      chk("t3_done_edge", 32'(de), 32'd40);
      chk("t3_done_count", 32'(nd), 32'd1);
      chk("t3_stim_walk", 32'(se), 32'd0);
      chk("t3_table", 32'(bus.table_out), 32'h97);
      chk("t3_match", 32'(bus.match), 32'h1);

      // reset at edge 17
      @(negedge clk);
      bus.expected = 8'h97;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk) bus.start = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      chk("t4_busy_pre", 32'(bus.busy), 32'h1);
      chk("t4_stim_pre", 32'(bus.stim), 32'h3);
      chk("t4_table_pre", 32'(bus.table_out), 32'h80);
      rst_n = 1'b0;
      #1;
      chk("t4_stim_rst", 32'(bus.stim), 32'h0);
      chk("t4_table_rst", 32'(bus.table_out), 32'h0);
      chk("t4_busy_rst", 32'(bus.busy), 32'h0);
      chk("t4_done_rst", 32'(bus.done), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      sweep(8'h97, -1, -1, de, nd, se);
      chk("t4_done_edge", 32'(de), 32'd40);
      chk("t4_stim_walk", 32'(se), 32'd0);
      chk("t4_table", 32'(bus.table_out), 32'h97);
      chk("t4_match", 32'(bus.match), 32'h1);

      // glitch during the last SETTLE cycle of row 3 (edges 18..19)
      sweep(8'h97, -1, 19, de, nd, se);
      chk("t6_table", 32'(bus.table_out), 32'h97);
`ifdef SWEEP_STABLE_CHECK_EN
      chk("t6_mask", 32'(bus.unstable_mask), 32'h10);
      chk("t6_match", 32'(bus.match), 32'h0);
`else
      chk("t6_mask", 32'(bus.unstable_mask), 32'h0);
      chk("t6_match", 32'(bus.match), 32'h1);
`endif

      // SETTLE_CYCLES = 1 instance, resp tied high
      @(negedge clk) bus1.start = 1'b1;
      @(posedge clk); #1;
      de = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk) bus1.start = 1'b0;
         @(posedge clk); #1;
         if (bus1.done === 1'b1 && de < 0) de = k;
      end
      chk("t5_done_edge", 32'(de), 32'd16);
      chk("t5_table", 32'(bus1.table_out), 32'hFF);
      chk("t5_match", 32'(bus1.match), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential characterisation block; the inverse of a combinational N-input logic circuit. It drives every input row into a circuit-under-test (CUT), waits for the output to settle, and captures the response.
- Reassembles the captured responses into the hex truth-table code the circuit was synthesised from, e.g. 0x97, and compares it against an expected code.
- Sits in the circuit-score test harness, between the bench controller and the CUT netlist.

Parameters:
- N_IN, 3, number of CUT inputs; table width TW = 2**N_IN.
- SETTLE_CYCLES, 4, cycles each row is held before sampling; must be >= 1 (0 is illegal, elaborate-time assertion).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- expected  input  TW  expected truth-table code; registered on accepted start
- resp  input  1  CUT output
- stim  output  N_IN  CUT input row; stim[N_IN-1] = in1, stim[N_IN-2] = in2, stim[0] = in3 (for N_IN = 3)
- busy  output  1  high from accepted start until DONE is left
- done  output  1  one-cycle pulse when the sweep completes
- table_out  output  TW  captured truth-table code
- match  output  1  table_out == registered expected; valid from done, held until the next start
- unstable_mask  output  TW  per-row instability flags (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - stim, table_out, unstable_mask, expected_q, row counter and settle counter all 0.
  - busy, done and match all 0.
- Bit ordering:
  - Row r maps to table_out bit [TW-1-r]; row 0 (all inputs low) is the MSB.
  - Example: the 3-input 0x97 function gives resp 1,0,0,1,0,1,1,1 for rows 0..7.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 is accepted.
  - On acceptance: expected_q <= expected; table_out <= 0; unstable_mask <= 0; match <= 0; row <= 0; stim <= 0; settle counter <= SETTLE_CYCLES-1; busy <= 1; next state SETTLE.
- SETTLE:
  - stim holds row r.
  - The counter decrements each cycle; at 0 the next state is SAMPLE.
- SAMPLE (one cycle):
  - table_out[TW-1-r] <= resp.
  - If r == TW-1, next state is DONE.
  - Otherwise: r <= r+1, stim <= r+1, counter reloaded, next state SETTLE.
- DONE (one cycle):
  - done = 1 and match = (table_out == expected_q).
  - stim returns to 0.
  - Next state IDLE; busy drops at exit.
- Latency: each row takes SETTLE_CYCLES+1 cycles. done is high TW*(SETTLE_CYCLES+1) edges after the start-accepting edge, i.e. 40 edges with the defaults.
- start while busy: ignored, with no restart and no queuing.
- Changes on expected mid-sweep: no effect, because the value is registered at start.
- Results hold: table_out, match and unstable_mask hold after DONE until the next accepted start.
- Reset mid-sweep: immediate return to IDLE with all outputs cleared. No done pulse.
- Row counter width: N_IN bits. No wrap occurs, because the last row exits to DONE.

Optional Feature:
- Macro: SWEEP_STABLE_CHECK_EN.
- Defined:
  - A register holds the previous cycle's resp.
  - In SAMPLE, if resp differs from that register (its value in the last SETTLE cycle), set unstable_mask[TW-1-r].
  - match is additionally forced to 0 if any unstable_mask bit is set.
- Undefined: unstable_mask is tied to 0 and match is the pure comparison.

Decomposition:
- Package sweep_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - a TW calculation function (2**n);
  - a row-to-bit-index function (TW-1-r).
- One sub-module, settle_timer: loadable down-counter with a load value of SETTLE_CYCLES-1 and a zero flag.

Test Plan:
- CUT = 0x97 netlist, expected = 8'h97, defaults → done at edge 40; table_out = 8'h97, match = 1, stim visits 0..7 in order for 5 cycles each.
- Same CUT, expected = 8'hE9 → table_out = 8'h97, match = 0.
- start pulsed again at edge 10 of a sweep, and expected changed mid-sweep → ignored; single done at edge 40; result unchanged.
- rst_n low at edge 17 → stim, table_out, busy and done are 0 asynchronously; a new start then gives a full correct sweep.
- SETTLE_CYCLES = 1, resp tied to 1 → done at edge 16; table_out = 8'hFF.
- With SWEEP_STABLE_CHECK_EN, resp toggled during the final SETTLE cycle of row 3 → unstable_mask = 8'h10 and match = 0; without the macro → unstable_mask = 0.
